// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX data-memory responder: size encodings,
// FSM states and the big-endian byte-lane helpers.
package dlx_mem_pkg;

    localparam logic [1:0] SZ_WORD    = 2'b00;
    localparam logic [1:0] SZ_BYTE_S  = 2'b01;
    localparam logic [1:0] SZ_BYTE_U  = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_MERGE = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    // Big-endian lane: byte offset 0 lives in bits [31:24], offset 3 in [7:0].
    // The LSB position of the lane is therefore (3 - off) * 8.
    function automatic logic [4:0] lane_lsb(input logic [1:0] byte_off);
        return {~byte_off, 3'b000};
    endfunction

    // Requests rejected without touching the SRAM.
    function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] byte_off);
        return (size == SZ_ILLEGAL) || ((size == SZ_WORD) && (byte_off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane datapath: extracts/extends a load result and builds the
// read-modify-write word for byte stores from the same lane select.
module dmem_lane
    import dlx_mem_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic [31:0] word,
    input  logic [7:0]  st_byte,
    output logic [31:0] ld_val,
    output logic [31:0] st_word
);

    logic [4:0]  lsb;
    logic [7:0]  lane;
    logic [31:0] lane_mask;

    // Lane extraction with sign/zero extension, and lane replacement for stores.
    always_comb begin
        lsb       = lane_lsb(byte_off);
        lane      = word[lsb +: 8];
        lane_mask = 32'h0000_00FF << lsb;
        unique case (size)
            SZ_WORD:   ld_val = word;
            SZ_BYTE_S: ld_val = {{24{lane[7]}}, lane};
            SZ_BYTE_U: ld_val = {24'h0, lane};
            default:   ld_val = 32'h0;
        endcase
        st_word = (word & ~lane_mask) | ({24'h0, st_byte} << lsb);
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: one request at a time, drives a word-wide
// synchronous SRAM with fixed read latency, byte stores via read-modify-write.
module dmem_responder
    import dlx_mem_pkg::*;
#(
    parameter int AW       = 10,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic [7:0]    byte_q, byte_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic [31:0]   ld_val;
    logic [31:0]   st_word;

    // Address bits above the SRAM range alias; they are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    // Lane unit works on the live SRAM read word so the load result and the
    // merged store word are both ready on the sampling edge.
    dmem_lane u_lane (
        .byte_off (off_q),
        .size     (size_q),
        .word     (mem_rdata),
        .st_byte  (byte_q),
        .ld_val   (ld_val),
        .st_word  (st_word)
    );

    // Next-state and registered-output computation for the request FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        off_d        = off_q;
        byte_d       = byte_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    size_d       = req_size;
                    off_d        = req_addr[1:0];
                    byte_d       = req_wdata[7:0];
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    if (req_is_err(req_size, req_addr[1:0])) begin
                        resp_err_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        // Strobes are registered, so they are set up here to be
                        // live during the ISSUE cycle.
                        state_d    = S_ISSUE;
                        mem_en_d   = 1'b1;
                        mem_we_d   = req_we && (req_size == SZ_WORD);
                        mem_addr_d = req_addr[AW+1:2];
                        if (req_we && (req_size == SZ_WORD)) begin
                            mem_wdata_d = req_wdata;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (we_q && (size_q == SZ_WORD)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (we_q) begin
                        state_d     = S_MERGE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = st_word;
                    end else begin
                        state_d      = S_RESP;
                        resp_rdata_d = ld_val;
                    end
                end
            end
            S_MERGE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            we_q         <= 1'b0;
            size_q       <= SZ_WORD;
            off_q        <= 2'b00;
            byte_q       <= 8'h0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            off_q        <= off_d;
            byte_q       <= byte_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU's MEM-stage data accesses: loads and stores, word and byte.
- Accepts one request at a time over a valid/ready handshake and drives a word-wide synchronous SRAM with a fixed read latency.
- Returns load data sign- or zero-extended and big-endian byte-laned, matching DLX bit numbering.
- Store-byte is done as an internal read-modify-write. `busy` gives the pipeline a stall source.

Parameters:
- AW, 10, SRAM word-address width; depth is 2**AW words.
- READ_LAT, 1, SRAM read latency in cycles from mem_en sample to mem_rdata valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  responder can accept this cycle
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=word, 01=byte signed (lb), 10=byte unsigned (lbu); 11 illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte stores use bits [7:0]
- resp_valid  out  1  response available
- resp_ready  in  1  CPU takes response
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  misaligned word access or illegal size
- busy  out  1  request accepted, response not yet consumed
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write strobe, valid with mem_en
- mem_addr  out  AW  SRAM word index = addr[AW+1:2]
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; wait counter and request registers cleared.
  - req_ready=1 once rst_n deasserts.
  - resp_valid, resp_err, busy, mem_en, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0.
- Reset mid-operation abandons the transaction: no SRAM write is issued after reset asserts, and the response is lost.
- States: IDLE, ISSUE, WAIT, MERGE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we, size, addr and wdata at the rising edge.
  - Error check: size==11, or size==00 with addr[1:0]!=0, goes directly to RESP with resp_err=1 and no SRAM access.
  - All other requests go to ISSUE.
- ISSUE (one cycle):
  - mem_en=1 and mem_addr come from the captured address.
  - Word store: mem_we=1, mem_wdata=wdata, next state RESP.
  - Load or byte store: mem_we=0, load counter with READ_LAT, next state WAIT.
- WAIT:
  - Decrement the counter each cycle; mem_rdata is sampled on the edge where the counter reaches 0.
  - Loads go to RESP. Byte stores go to MERGE.
- Load lane select (big-endian): addr[1:0]=0 takes rdata[31:24], 1 takes [23:16], 2 takes [15:8], 3 takes [7:0].
  - Size 01 sign-extends the byte from its bit 7; size 10 zero-extends; word loads return rdata unchanged.
- MERGE (one cycle):
  - mem_en=1, mem_we=1; mem_wdata is the sampled word with the selected lane replaced by wdata[7:0]. Other lanes are unchanged.
  - Next state RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - Leave for IDLE on the edge where resp_ready=1. req_ready=0 in RESP, so there is no overlap between requests.
- Latency from acceptance edge to resp_valid high:
  - error: 1 cycle
  - word store: 2 cycles
  - load: READ_LAT+2 cycles
  - byte store: READ_LAT+3 cycles
- busy=1 from the acceptance edge until the resp handshake edge; equivalent to state!=IDLE.
- req_ready=0 in every non-IDLE state; req_valid is ignored there.
- Address wrap-around: bits above AW+1 are ignored, so addresses alias modulo 2**(AW+2).
- Outputs in IDLE: mem_en=0 and mem_we=0. mem_we is never 1 while mem_en is 0.
- resp_ready held 1 continuously gives back-to-back service with one IDLE cycle between transactions.

Decomposition:
- Shared package dlx_mem_pkg:
  - size encodings SZ_WORD, SZ_BYTE_S, SZ_BYTE_U
  - state enum
  - lane-select function used by both load extract and store merge
- One natural sub-module: dmem_lane, a combinational unit taking addr[1:0], size, word and byte, and producing both the extracted load value and the merged store word.
- FSM, counter and registers live in dmem_responder.

Test Plan:
- Word load, READ_LAT=1, SRAM[0x10>>2]=0x8899AABB, addr=0x10: resp_rdata=0x8899AABB, resp_valid asserted 3 cycles after acceptance, resp_err=0.
- Byte load, same word, addr=0x12, size 01 then 10: rdata=0xFFFFFFAA (signed), then 0x000000AA (unsigned).
- Store byte, addr=0x11, wdata=0x5C: one SRAM read then one write of 0x885CAABB; a subsequent word load returns 0x885CAABB; resp_valid asserted 4 cycles after acceptance.
- Misaligned word store, addr=0x13: resp_err=1 after 1 cycle, mem_en never asserted, SRAM unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP: resp_valid, rdata and err stay stable, req_ready=0, a new req_valid is not accepted; it is accepted 1 cycle after resp_ready rises.
- rst_n pulsed low during WAIT of a byte store: all outputs 0 immediately, no mem_we pulse, SRAM word unchanged, req_ready=1 after release; repeat the test with READ_LAT=4.
